// File: rtl/prores_dc_entropy_encoder_p.sv
// ProRes DC-coefficient entropy encoder: slice-scoped DC prediction, sign
// flip, adaptive Exp-Golomb/Rice codebook selection and per-slice bit count,
// as a two-stage valid/ready pipeline.
module prores_dc_entropy_encoder_p #(
  parameter  int COEFF_W = 16,
  parameter  int FIRST_K = 5,
  parameter  int BITS_W  = 20,
  localparam int CODE_W  = 2*COEFF_W+3,
  localparam int LEN_W   = $clog2(CODE_W+1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [COEFF_W-1:0] in_dc,
  input  logic                      in_first,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CODE_W-1:0]         out_code,
  output logic [LEN_W-1:0]          out_len,
  output logic                      out_last,
  output logic [BITS_W-1:0]         slice_bits
);

  localparam int DW = COEFF_W + 1;  // difference width
  localparam int NW = COEFF_W + 2;  // mapped symbol width
  localparam int MW = NW + 1;       // Exp-Golomb m = n + 2^k

  typedef enum logic [2:0] {CB_EGF, CB_EG0, CB_EG1, CB_RICE2, CB_ESC, CB_EG3} cb_e;

  function automatic int unsigned msb_idx(input logic [MW-1:0] v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < MW; i++)
      if (v[i]) r = i;
    return r;
  endfunction

  logic                      live;
  logic                      s1_full;
  logic                      s1_take;
  logic                      s2_adv;
  logic signed [COEFF_W-1:0] prev_dc;
  logic [DW-1:0]             prev_abs;
  logic                      prev_neg;
  logic [NW-1:0]             s1_n;
  cb_e                       s1_cb;
  logic                      s1_first;
  logic                      s1_last;

  assign s2_adv   = s1_full && (!out_valid || out_ready);
  assign in_ready = live && (!s1_full || s2_adv);
  assign s1_take  = in_valid && in_ready;

  // Stage 1 datapath: prediction difference, sign flip, symbol map, codebook class.
  logic signed [DW-1:0] dc_x, prev_x, d, e;
  logic [DW-1:0]        abs_d;
  logic [NW-1:0]        n;
  cb_e                  cb;
  always_comb begin
    dc_x   = DW'(in_dc);
    prev_x = DW'(prev_dc);
    d      = dc_x - prev_x;
    abs_d  = d[DW-1] ? -d : d;
    if (in_first)      e = dc_x;
    else if (prev_neg) e = -d;
    else               e = d;
    // s(e) = ~(2e) for negative e in two's complement
    n  = e[DW-1] ? {~e, 1'b1} : {e, 1'b0};
    cb = CB_EG3;
    if (in_first) cb = CB_EGF;
    else begin
      case (prev_abs)
        DW'(0):  cb = CB_EG0;
        DW'(1):  cb = CB_EG1;
        DW'(2):  cb = (n < NW'(8)) ? CB_RICE2 : CB_ESC;
        default: cb = CB_EG3;
      endcase
    end
  end

  // Stage 2 datapath: codeword, length and running slice bit total.
  logic [NW-1:0]     n_src;
  logic [MW-1:0]     m;
  int unsigned       k, lg, len_i;
  logic [CODE_W-1:0] code_c;
  logic [LEN_W-1:0]  len_c;
  logic [BITS_W-1:0] base, bits_c;
  logic [BITS_W:0]   sum;
  always_comb begin
    n_src = (s1_cb == CB_ESC) ? s1_n - NW'(8) : s1_n;
    case (s1_cb)
      CB_EGF:  k = FIRST_K;
      CB_EG0:  k = 0;
      CB_EG1:  k = 1;
      default: k = 3;
    endcase
    m      = MW'(n_src) + (MW'(1) << k);
    lg     = msb_idx(m);
    len_i  = 2*lg + 1 - k;
    code_c = CODE_W'(m);
    if (s1_cb == CB_ESC) len_i = len_i + 3;
    if (s1_cb == CB_RICE2) begin
      len_i  = 32'(s1_n >> 2) + 3;
      code_c = CODE_W'({1'b1, s1_n[1:0]});
    end
    len_c  = LEN_W'(len_i);
    // The slice_bits register always holds the total of the most recently
    // loaded beat, which is exactly the accumulator the next beat builds on;
    // beats reach stage 2 strictly in output order.
    base   = s1_first ? '0 : slice_bits;
    sum    = {1'b0, base} + (BITS_W+1)'(len_c);
    bits_c = sum[BITS_W] ? '1 : sum[BITS_W-1:0];
  end

  // Input acceptance is enabled from the first clock edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) live <= 1'b0;
    else          live <= 1'b1;
  end

  // Predictor state advances only on accepted beats.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_dc  <= '0;
      prev_abs <= DW'(3);
      prev_neg <= 1'b0;
    end else if (s1_take) begin
      prev_dc  <= in_dc;
      prev_abs <= in_first ? DW'(3) : abs_d;
      prev_neg <= in_first ? 1'b0 : d[DW-1];
    end
  end

  // Stage 1 register slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_full  <= 1'b0;
      s1_n     <= '0;
      s1_cb    <= CB_EG3;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else if (s1_take) begin
      s1_full  <= 1'b1;
      s1_n     <= n;
      s1_cb    <= cb;
      s1_first <= in_first;
      s1_last  <= in_last;
    end else if (s2_adv) begin
      s1_full  <= 1'b0;
    end
  end

  // Stage 2 / output register slot, held while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_code   <= '0;
      out_len    <= '0;
      out_last   <= 1'b0;
      slice_bits <= '0;
    end else if (s2_adv) begin
      out_valid  <= 1'b1;
      out_code   <= code_c;
      out_len    <= len_c;
      out_last   <= s1_last;
      slice_bits <= bits_c;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prores_dc_entropy_encoder_p.sv
// Scoreboard bench for prores_dc_entropy_encoder_p: directed codebook cases,
// backpressure, mid-stream reset and randomized slices against a reference model.
module tb_prores_dc_entropy_encoder_p;

  localparam int COEFF_W = 16;
  localparam int FIRST_K = 5;
  localparam int BITS_W  = 20;
  localparam int CODE_W  = 2*COEFF_W+3;
  localparam int LEN_W   = $clog2(CODE_W+1);
  localparam longint BITS_MAX = (64'sd1 <<< BITS_W) - 1;

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic signed [COEFF_W-1:0] in_dc = '0;
  logic                      in_first = 1'b0;
  logic                      in_last = 1'b0;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic [CODE_W-1:0]         out_code;
  logic [LEN_W-1:0]          out_len;
  logic                      out_last;
  logic [BITS_W-1:0]         slice_bits;

  prores_dc_entropy_encoder_p #(
    .COEFF_W(COEFF_W),
    .FIRST_K(FIRST_K),
    .BITS_W (BITS_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dc     (in_dc),
    .in_first  (in_first),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_len   (out_len),
    .out_last  (out_last),
    .slice_bits(slice_bits)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint code;
    longint len;
    longint last;
    longint bits;
  } exp_t;

  exp_t   sb[$];
  int     errors = 0;
  int     checks = 0;
  bit     hold_low = 1'b0;
  bit     rand_bp = 1'b0;

  // Reference model state (spec-level predictor and slice accumulator)
  longint m_prev_dc = 0;
  longint m_prev_abs = 3;
  bit     m_prev_neg = 1'b0;
  longint m_acc = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Exp-Golomb of order k: m = n + 2^k, len = 2*(floor(log2 m) - k) + k + 1
  task automatic eg(input longint nn, input int k, output longint code, output longint len);
    longint mm;
    int lg;
    mm = nn + (64'sd1 <<< k);
    lg = 0;
    while ((mm >>> (lg + 1)) != 0) lg++;
    len  = 2*(lg - k) + k + 1;
    code = mm;
  endtask

  task automatic model(input longint dc, input bit first, output longint code, output longint len);
    longint dd, ee, nn;
    if (first) ee = dc;
    else begin
      dd = dc - m_prev_dc;
      ee = m_prev_neg ? -dd : dd;
    end
    nn = (ee >= 0) ? 2*ee : -2*ee - 1;
    if (first)                eg(nn, FIRST_K, code, len);
    else if (m_prev_abs == 0) eg(nn, 0, code, len);
    else if (m_prev_abs == 1) eg(nn, 1, code, len);
    else if (m_prev_abs == 2) begin
      if (nn < 8) begin
        len  = (nn / 4) + 1 + 2;
        code = 4 + (nn % 4);
      end else begin
        eg(nn - 8, 3, code, len);
        len = len + 3;
      end
    end else eg(nn, 3, code, len);
    if (first) begin
      m_prev_abs = 3;
      m_prev_neg = 1'b0;
    end else begin
      m_prev_abs = (dd < 0) ? -dd : dd;
      m_prev_neg = (dd < 0);
    end
    m_prev_dc = dc;
  endtask

  // Offer one beat until accepted; elen != 0 supplies a hand-derived codeword.
  task automatic send(input longint dc, input bit first, input bit last,
                      input longint ecode = 0, input longint elen = 0);
    bit got;
    longint code, len, bits;
    exp_t ex;
    got = 1'b0;
    in_dc    = COEFF_W'(dc);
    in_first = first;
    in_last  = last;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      if (got) break;
    end
    in_valid = 1'b0;
    if (!got) begin
      check("send_accept_timeout", 0, 1);
      return;
    end
    model(dc, first, code, len);
    if (elen != 0) begin
      code = ecode;
      len  = elen;
    end
    bits = (first ? 0 : m_acc) + len;
    if (bits > BITS_MAX) bits = BITS_MAX;
    m_acc = bits;
    ex.code = code;
    ex.len  = len;
    ex.last = last;
    ex.bits = bits;
    sb.push_back(ex);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 500) check("drain_timeout", longint'(sb.size()), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},   in_ready, 0);
    check({tag, "_out_valid"},  out_valid, 0);
    check({tag, "_out_code"},   out_code, 0);
    check({tag, "_out_len"},    out_len, 0);
    check({tag, "_out_last"},   out_last, 0);
    check({tag, "_slice_bits"}, slice_bits, 0);
  endtask

  // Sink-side ready generator, updated 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    out_ready = hold_low ? 1'b0 : (rand_bp ? ($urandom_range(3) != 0) : 1'b1);
  end

  // Monitor: pops the scoreboard on each output handshake and checks hold during stalls.
  logic [CODE_W-1:0] h_code;
  logic [LEN_W-1:0]  h_len;
  logic              h_last;
  logic [BITS_W-1:0] h_bits;
  bit                h_stall = 1'b0;
  always @(negedge clk) begin
    exp_t ex;
    if (!reset_n) h_stall = 1'b0;
    else begin
      if (h_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_code",  out_code, h_code);
        check("hold_len",   out_len, h_len);
        check("hold_last",  out_last, h_last);
        check("hold_bits",  slice_bits, h_bits);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_output", 1, 0);
        else begin
          ex = sb.pop_front();
          check("out_code",   out_code, ex.code);
          check("out_len",    out_len, ex.len);
          check("out_last",   out_last, ex.last);
          check("slice_bits", slice_bits, ex.bits);
        end
      end
      h_stall = out_valid && !out_ready;
      h_code  = out_code;
      h_len   = out_len;
      h_last  = out_last;
      h_bits  = slice_bits;
    end
  end

  initial begin
    logic signed [COEFF_W-1:0] r;
    longint dc;
    int slen;

    // Reset state
    #1;
    check_reset_outputs("reset");
    #12;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_release", in_ready, 1);

    // First-block coding
    send(0, 1, 1, 'h20, 6);
    send(-1, 1, 1, 'h21, 6);

    // Codebook walk: EG k5, EG k3, EG k3, EG k0 -> 15 bits
    send(0, 1, 0, 'h20, 6);
    send(3, 0, 0, 'hE, 4);
    send(3, 0, 0, 'h8, 4);
    send(3, 0, 1, 'h1, 1);

    // Rice k2 and escape
    send(0, 1, 0, 'h20, 6);
    send(2, 0, 0, 'hC, 4);
    send(4, 0, 0, 'h4, 4);
    send(9, 0, 1, 'hA, 7);

    // Sign flip
    send(0, 1, 0, 'h20, 6);
    send(-2, 0, 0, 'hB, 4);
    send(-4, 0, 1, 'h4, 4);
    drain();

    // Backpressure: 8-beat slice, sink stalled while the pipe fills
    hold_low = 1'b1;
    send(100, 1, 0);
    send(98, 0, 0);
    in_dc    = COEFF_W'(97);
    in_first = 1'b0;
    in_last  = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    check("in_ready_falls_when_full", in_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    hold_low = 1'b0;
    send(97, 0, 0);
    send(101, 0, 0);
    send(101, 0, 0);
    send(90, 0, 0);
    send(-300, 0, 0);
    send(-298, 0, 1);
    // Next slice restarts predictor and bit count
    send(7, 1, 0);
    send(8, 0, 1);
    drain();

    // Asynchronous reset mid-stream
    send(10, 1, 0);
    send(20, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    sb.delete();
    m_prev_dc  = 0;
    m_prev_abs = 3;
    m_prev_neg = 1'b0;
    m_acc      = 0;
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_midreset", in_ready, 1);
    send(3, 0, 1, 'hE, 4);
    drain();

    // Randomized slices with random sink backpressure
    for (int s = 0; s < 40; s++) begin
      rand_bp = (s % 2) == 1;
      slen = $urandom_range(1, 8);
      for (int b = 0; b < slen; b++) begin
        if ($urandom_range(1) == 1) begin
          r  = COEFF_W'($urandom);
          dc = r;
        end else begin
          dc = longint'($urandom_range(40)) - 20;
        end
        send(dc, b == 0, b == slen - 1);
        if ($urandom_range(3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end
    rand_bp = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
